axi_to_mem_beat_gen: RTL



---
 rtl/axi_to_mem_beat_gen.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_to_mem_beat_gen.sv
// axi_to_mem_beat_gen
// Expands one AXI address-channel request (AW or AR) into len+1 per-beat
// memory requests carrying byte address, ID and last flag. FIXED, INCR and
// WRAP address sequencing; unsupported encodings are expanded as INCR.
//
// Optional feature macro: AXI_BEAT_GEN_ERR_EN
//   defined   -> beat_err_o exists and flags every beat of a burst that used a
//                reserved burst type, an illegal WRAP length or an oversize
//                beat size.
//   undefined -> beat_err_o and its logic are absent.
//
// Handshakes: a transfer on either channel happens in a cycle where valid and
// ready are both high at the rising edge of clk_i. Once beat_valid_o is high
// it stays high, and every beat output stays unchanged, until beat_ready_i is
// seen (only flush_i or rst_i may withdraw it). ax_ready_o never depends on
// ax_valid_i, so an upstream register may wait for ready before raising valid.

module axi_to_mem_beat_gen #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  // address request
  input  logic                 ax_valid_i,
  output logic                 ax_ready_o,
  input  logic [IdWidth-1:0]   ax_id_i,
  input  logic [AddrWidth-1:0] ax_addr_i,
  input  logic [7:0]           ax_len_i,
  input  logic [2:0]           ax_size_i,
  input  logic [1:0]           ax_burst_i,
  // per-beat memory request
  output logic                 beat_valid_o,
  input  logic                 beat_ready_i,
  output logic [AddrWidth-1:0] beat_addr_o,
  output logic [IdWidth-1:0]   beat_id_o,
  output logic                 beat_last_o,
  // FSM state for observation (0 = IDLE, 1 = BURST)
  output logic                 dbg_state_o
`ifdef AXI_BEAT_GEN_ERR_EN
  ,
  output logic                 beat_err_o
`endif
);

  // Largest beat size the memory bus can carry, as log2 of bytes.
  localparam int unsigned MaxSize = $clog2(DataWidth / 8);

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  localparam logic [AddrWidth-1:0] AddrOne = AddrWidth'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Latched burst context
  logic [AddrWidth-1:0] addr_q;
  logic [IdWidth-1:0]   id_q;
  logic [7:0]           len_q;
  logic [2:0]           size_q;
  logic [1:0]           mode_q;
  logic [7:0]           cnt_q;
  logic                 last_q;
`ifdef AXI_BEAT_GEN_ERR_EN
  logic                 err_q;
`endif

  // Control strobes from the FSM
  logic load;     // accept request into the beat registers
  logic advance;  // step to the next beat of the current burst

  // Decoded incoming request
  logic       req_wrap_len_ok;
  logic       req_oversize;
  logic       req_err;
  logic [1:0] req_mode;

  // Address of the beat following addr, for the latched burst shape.
  // Both INCR and WRAP step from the size-aligned address, so only the first
  // beat of a burst can be unaligned.
  function automatic logic [AddrWidth-1:0] next_addr(
    input logic [AddrWidth-1:0] addr,
    input logic [7:0]           len,
    input logic [2:0]           size,
    input logic [1:0]           mode
  );
    logic [AddrWidth-1:0] bytes;
    logic [AddrWidth-1:0] aligned;
    logic [AddrWidth-1:0] incr;
    logic [AddrWidth-1:0] mask;
    bytes   = AddrOne << size;
    aligned = addr & ~(bytes - AddrOne);
    incr    = aligned + bytes;
    // Wrap window is the total burst size in bytes; only legal WRAP lengths
    // reach here, so the window is a power of two.
    mask    = ((AddrWidth'(len) + AddrOne) << size) - AddrOne;
    case (mode)
      BurstFixed: next_addr = addr;
      BurstWrap:  next_addr = (aligned & ~mask) | (incr & mask);
      default:    next_addr = incr;
    endcase
  endfunction

  // Classify the request: anything unsupported is expanded as INCR.
  always_comb begin
    req_wrap_len_ok = (ax_len_i == 8'd1) || (ax_len_i == 8'd3) ||
                      (ax_len_i == 8'd7) || (ax_len_i == 8'd15);
    req_oversize    = (ax_size_i > 3'(MaxSize));
    req_err         = (ax_burst_i == 2'b11) ||
                      ((ax_burst_i == BurstWrap) && !req_wrap_len_ok) ||
                      req_oversize;
    req_mode        = req_err ? BurstIncr : ax_burst_i;
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state, request ready and datapath strobes. Flush and reset win
  // over everything; a last-beat handshake reopens the request channel so a
  // following burst loads without a bubble.
  always_comb begin
    state_d    = state_q;
    ax_ready_o = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    case (state_q)
      IDLE: begin
        ax_ready_o = !flush_i;
        if (ax_valid_i && !flush_i) begin
          load    = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (beat_ready_i) begin
          if (last_q) begin
            ax_ready_o = 1'b1;
            if (ax_valid_i) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      ax_ready_o = 1'b0;
      load       = 1'b0;
      advance    = 1'b0;
      state_d    = IDLE;
    end
  end

  // Beat registers: load a new burst or step to the next beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
      id_q   <= '0;
      len_q  <= '0;
      size_q <= '0;
      mode_q <= BurstIncr;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else if (load) begin
      addr_q <= ax_addr_i;
      id_q   <= ax_id_i;
      len_q  <= ax_len_i;
      size_q <= ax_size_i;
      mode_q <= req_mode;
      cnt_q  <= '0;
      last_q <= (ax_len_i == 8'd0);
    end else if (advance) begin
      addr_q <= next_addr(addr_q, len_q, size_q, mode_q);
      cnt_q  <= cnt_q + 8'd1;
      last_q <= ((cnt_q + 8'd1) == len_q);
    end else if ((state_q == BURST) && (state_d == IDLE)) begin
      last_q <= 1'b0;
    end
  end

`ifdef AXI_BEAT_GEN_ERR_EN
  // Error flag travels with the burst it was decoded for.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (load) begin
      err_q <= req_err;
    end
  end

  assign beat_err_o = err_q;
`endif

  assign beat_valid_o = (state_q == BURST);
  assign beat_addr_o  = addr_q;
  assign beat_id_o    = id_q;
  assign beat_last_o  = last_q;
  assign dbg_state_o  = state_q;

endmodule
